// File: rtl/aes_pkg.sv
// Shared definitions for the AES core arbiter and its helpers.
package aes_pkg;

    localparam int AES_BLK_W   = 128;
    localparam int NUM_REQ_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: rotate requests by the pointer, take the
// lowest set bit, rotate the winner back into the original index space.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    logic [N-1:0] rot;
    int           src;
    int           pos;
    int           back;

    always_comb begin
        rot     = '0;
        src     = 0;
        pos     = 0;
        back    = 0;
        gnt     = '0;
        gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            src = k + int'(ptr);
            if (src >= N) src = src - N;
            rot[k] = req[IDW'(src)];
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) pos = k;
        end
        back = pos + int'(ptr);
        if (back >= N) back = back - N;
        if (|rot) begin
            gnt[IDW'(back)] = 1'b1;
            gnt_idx         = IDW'(back);
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// Round-robin scheduler sharing one iterative AES-128 core among NUM_REQ requesters.
// Optional watchdog enabled by defining AES_ARB_TIMEOUT_EN.
module aes_core_arbiter
    import aes_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                           iClk,
    input  logic                           iRst,
    input  logic [NUM_REQ-1:0]             iReqValid,
    output logic [NUM_REQ-1:0]             oReqReady,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   iReqPlaintext,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   iReqKey,
    output logic                           oRspValid,
    input  logic                           iRspReady,
    output logic [ID_W-1:0]                oRspId,
    output logic [AES_BLK_W-1:0]           oRspData,
    output logic                           oRspErr,
    output logic                           oCoreStart,
    output logic [AES_BLK_W-1:0]           oCorePlaintext,
    output logic [AES_BLK_W-1:0]           oCoreKey,
    input  logic [AES_BLK_W-1:0]           iCoreCiphertext,
    input  logic                           iCoreDone,
    output logic                           oBusy
);

    arb_state_t          state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     job_id;
    logic [ID_W-1:0]     gnt_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic                done_q;
    logic                first_wait;
    logic                done_rise;
    logic                tmo_hit;

    rr_arbiter #(
        .N   (NUM_REQ),
        .IDW (ID_W)
    ) u_rr (
        .req     (iReqValid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign oReqReady = (state == S_IDLE && !iRst) ? gnt : '0;

    // The core's sticky done from the previous job may still be visible on the
    // first wait cycle, so that cycle never counts as completion.
    assign done_rise = iCoreDone & ~done_q & ~first_wait;

`ifdef AES_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign oRspErr = err_q;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_START)
                tmo_cnt <= '0;
            else if (state == S_WAIT)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (state == S_WAIT && !done_rise && tmo_hit)
                err_q <= 1'b1;
            else if (state == S_RESP && iRspReady)
                err_q <= 1'b0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign oRspErr = 1'b0;
`endif

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state          <= S_IDLE;
            ptr            <= '0;
            job_id         <= '0;
            done_q         <= 1'b0;
            first_wait     <= 1'b0;
            oCoreStart     <= 1'b0;
            oCorePlaintext <= '0;
            oCoreKey       <= '0;
            oRspValid      <= 1'b0;
            oRspId         <= '0;
            oRspData       <= '0;
            oBusy          <= 1'b0;
        end else begin
            done_q     <= iCoreDone;
            oCoreStart <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|gnt) begin
                        oCorePlaintext <= AES_BLK_W'(iReqPlaintext >> (AES_BLK_W * int'(gnt_idx)));
                        oCoreKey       <= AES_BLK_W'(iReqKey >> (AES_BLK_W * int'(gnt_idx)));
                        job_id         <= gnt_idx;
                        ptr            <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        oCoreStart     <= 1'b1;
                        oBusy          <= 1'b1;
                        state          <= S_START;
                    end
                end
                S_START: begin
                    first_wait <= 1'b1;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    first_wait <= 1'b0;
                    if (done_rise) begin
                        oRspData  <= iCoreCiphertext;
                        oRspId    <= job_id;
                        oRspValid <= 1'b1;
                        state     <= S_RESP;
                    end else if (tmo_hit) begin
                        oRspData  <= '0;
                        oRspId    <= job_id;
                        oRspValid <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (iRspReady) begin
                        oRspValid <= 1'b0;
                        oBusy     <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: behavioural AES core stand-in, vector table, scoreboard.
module tb_aes_core_arbiter;

    localparam int NREQ     = 4;
    localparam int CORE_LAT = 14;
`ifdef AES_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 64;
`endif

    localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] XORC = 128'h5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a;

    logic              iClk;
    logic              iRst;
    logic [NREQ-1:0]   iReqValid;
    logic [NREQ-1:0]   oReqReady;
    logic [NREQ*128-1:0] iReqPlaintext;
    logic [NREQ*128-1:0] iReqKey;
    logic              oRspValid;
    logic              iRspReady;
    logic [1:0]        oRspId;
    logic [127:0]      oRspData;
    logic              oRspErr;
    logic              oCoreStart;
    logic [127:0]      oCorePlaintext;
    logic [127:0]      oCoreKey;
    logic [127:0]      iCoreCiphertext;
    logic              iCoreDone;
    logic              oBusy;

    typedef struct {
        int           idx;
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] exp_d;
        bit           perturb;
        int           hold;
    } vec_t;

    vec_t         vecs[6];
    logic [130:0] exp_q[$];
    logic [130:0] sb_exp;
    int           checks = 0;
    int           errors = 0;
    int           start_total = 0;

    aes_core_arbiter #(
        .NUM_REQ (NREQ),
        .ID_W    (2),
        .TIMEOUT (TMO)
    ) dut (
        .iClk            (iClk),
        .iRst            (iRst),
        .iReqValid       (iReqValid),
        .oReqReady       (oReqReady),
        .iReqPlaintext   (iReqPlaintext),
        .iReqKey         (iReqKey),
        .oRspValid       (oRspValid),
        .iRspReady       (iRspReady),
        .oRspId          (oRspId),
        .oRspData        (oRspData),
        .oRspErr         (oRspErr),
        .oCoreStart      (oCoreStart),
        .oCorePlaintext  (oCorePlaintext),
        .oCoreKey        (oCoreKey),
        .iCoreCiphertext (iCoreCiphertext),
        .iCoreDone       (iCoreDone),
        .oBusy           (oBusy)
    );

    // clock / reset
    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    // Core stand-in: known FIPS-197 vectors map to their ciphertexts, anything
    // else to a simple keyed mix. Result follows the live operands, as a core
    // with combinational key expansion would.
    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
        if (pt == P_C1 && key == K_C1) return C_C1;
        if (pt == P_B && key == K_B) return C_B;
        return pt ^ {key[63:0], key[127:64]} ^ XORC;
    endfunction

    logic core_run;
    int   core_cnt;
    logic core_done;
    bit   core_stuck = 1'b0;

    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            core_run  <= 1'b0;
            core_cnt  <= 0;
            core_done <= 1'b0;
        end else if (oCoreStart) begin
            core_run <= 1'b1;
            core_cnt <= 0;
        end else if (core_run) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == 0) core_done <= 1'b0;
            if (core_cnt == CORE_LAT - 1) begin
                core_run  <= 1'b0;
                core_done <= !core_stuck;
            end
        end
    end

    assign iCoreDone       = core_done;
    assign iCoreCiphertext = core_fn(oCorePlaintext, oCoreKey);

    always @(negedge iClk) if (oCoreStart) start_total++;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // scoreboard
    always @(negedge iClk) begin
        if (!iRst && oRspValid && iRspReady) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 256'(1), 256'(0));
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_rsp", 256'({oRspErr, oRspId, oRspData}), 256'(sb_exp));
            end
        end
    end

    // driver tasks
    task automatic set_req(input int idx, input logic [127:0] pt, input logic [127:0] key);
        iReqPlaintext = (iReqPlaintext & ~(512'({128{1'b1}}) << (128 * idx))) | (512'(pt) << (128 * idx));
        iReqKey       = (iReqKey & ~(512'({128{1'b1}}) << (128 * idx))) | (512'(key) << (128 * idx));
    endtask

    task automatic wait_ready(input logic [3:0] mask, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge iClk);
            if (|(oReqReady & mask)) ok = 1'b1;
        end
    endtask

    task automatic run_job(input vec_t v);
        bit         ok;
        int         n;
        int         snap;
        logic [3:0] oh;
        oh   = 4'(1 << v.idx);
        snap = start_total;
        @(posedge iClk); #1;
        if (v.hold > 0) iRspReady = 1'b0;
        set_req(v.idx, v.pt, v.key);
        iReqValid = oh;
        wait_ready(oh, 40, ok);
        if (!ok) begin
            chk("grant_timeout", 256'(0), 256'(1));
            iReqValid = '0;
            iRspReady = 1'b1;
            return;
        end
        chk("grant_onehot", 256'(oReqReady), 256'(oh));
        exp_q.push_back({1'b0, 2'(v.idx), v.exp_d});
        @(posedge iClk); #1;
        iReqValid = '0;
        if (v.perturb) set_req(v.idx, {4{$urandom}}, {4{$urandom}});
        @(negedge iClk);
        chk("busy_start", 256'({oBusy, oCoreStart, oReqReady}), 256'({1'b1, 1'b1, 4'b0}));
        if (v.perturb) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge iClk); #1;
                set_req(v.idx, {4{$urandom}}, {4{$urandom}});
                @(negedge iClk);
                chk("core_operands_stable", {oCorePlaintext, oCoreKey}, {v.pt, v.key});
            end
        end
        n = 0;
        while (!oRspValid && n < 60) begin
            @(negedge iClk);
            n++;
        end
        if (!oRspValid) begin
            chk("rsp_timeout", 256'(0), 256'(1));
            iRspReady = 1'b1;
            return;
        end
        chk("rsp_id", 256'(oRspId), 256'(v.idx));
        chk("rsp_data", 256'(oRspData), 256'(v.exp_d));
        chk("rsp_err", 256'(oRspErr), 256'(0));
        if (v.hold > 0) begin
            @(posedge iClk); #1;
            iReqValid = 4'(1 << ((v.idx + 1) % NREQ));
            for (int i = 0; i < v.hold; i++) begin
                @(negedge iClk);
                chk("rsp_hold", 256'({oRspValid, oReqReady, oRspId, oRspData}),
                    256'({1'b1, 4'b0, 2'(v.idx), v.exp_d}));
            end
            @(posedge iClk); #1;
            iRspReady = 1'b1;
            iReqValid = '0;
            @(negedge iClk);
        end
        @(posedge iClk);
        @(negedge iClk);
        chk("rsp_drop", 256'(oRspValid), 256'(0));
        chk("start_pulses", 256'(start_total - snap), 256'(1));
    endtask

    task automatic run_fair();
        bit         ok;
        int         n;
        logic [3:0] oh;
        @(posedge iClk); #1;
        for (int i = 0; i < NREQ; i++) set_req(i, P_B, K_B);
        iReqValid = 4'hf;
        for (int k = 0; k < 5; k++) begin
            oh = 4'(1 << (k % NREQ));
            wait_ready(4'hf, 60, ok);
            if (!ok) begin
                chk("fair_timeout", 256'(0), 256'(1));
                break;
            end
            chk("fair_grant", 256'(oReqReady), 256'(oh));
            exp_q.push_back({1'b0, 2'(k % NREQ), C_B});
            @(posedge iClk);
        end
        #1;
        iReqValid = '0;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge iClk);
            n++;
        end
        chk("fair_drain", 256'(exp_q.size()), 256'(0));
    endtask

    task automatic run_reset_mid();
        bit   ok;
        bit   seen;
        vec_t v;
        @(posedge iClk); #1;
        set_req(3, P_C1, K_C1);
        iReqValid = 4'b1000;
        wait_ready(4'b1000, 40, ok);
        if (!ok) begin
            chk("rstmid_grant_timeout", 256'(0), 256'(1));
            iReqValid = '0;
            return;
        end
        @(posedge iClk); #1;
        iReqValid = 4'b0001;
        repeat (5) @(posedge iClk);
        @(negedge iClk);
        chk("busy_wait", 256'({oBusy, oReqReady}), 256'({1'b1, 4'b0}));
        #3;
        iRst = 1'b1;
        #1;
        chk("rst_async_ctl", 256'({oReqReady, oRspValid, oRspId, oRspErr, oCoreStart, oBusy}), 256'(0));
        chk("rst_async_data", 256'(oRspData), 256'(0));
        chk("rst_async_core", {oCorePlaintext, oCoreKey}, 256'(0));
        repeat (2) @(posedge iClk);
        #1;
        iReqValid = '0;
        iRst      = 1'b0;
        seen      = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge iClk);
            if (oRspValid) seen = 1'b1;
        end
        chk("rst_no_rsp", 256'(seen), 256'(0));
        v = '{0, P_C1, K_C1, C_C1, 1'b0, 0};
        run_job(v);
    endtask

`ifdef AES_ARB_TIMEOUT_EN
    task automatic run_timeout();
        bit ok;
        int n;
        core_stuck = 1'b1;
        @(posedge iClk); #1;
        set_req(0, P_B, K_B);
        iReqValid = 4'b0001;
        wait_ready(4'b0001, 40, ok);
        if (!ok) begin
            chk("tmo_grant_timeout", 256'(0), 256'(1));
            iReqValid  = '0;
            core_stuck = 1'b0;
            return;
        end
        exp_q.push_back({1'b1, 2'd0, 128'h0});
        @(posedge iClk); #1;
        iReqValid = '0;
        n = 0;
        do begin
            @(negedge iClk);
            n++;
        end while (!oRspValid && n < 100);
        chk("tmo_latency", 256'(n), 256'(TMO + 2));
        chk("tmo_err_data", 256'({oRspErr, oRspData}), 256'({1'b1, 128'h0}));
        @(posedge iClk);
        @(negedge iClk);
        chk("tmo_err_clear", 256'({oRspValid, oRspErr}), 256'(0));
        core_stuck = 1'b0;
    endtask
`endif

    initial begin
        iRst          = 1'b1;
        iReqValid     = '0;
        iReqPlaintext = '0;
        iReqKey       = '0;
        iRspReady     = 1'b1;

        vecs[0] = '{2, P_C1, K_C1, C_C1, 1'b0, 0};
        vecs[1] = '{0, P_B, K_B, C_B, 1'b1, 0};
        vecs[2] = '{3, 128'h0, 128'h0, XORC, 1'b0, 0};
        vecs[3] = '{1, P_C1, K_C1, C_C1, 1'b0, 20};
        vecs[4] = '{1, 128'h0, 128'h1, 128'h5a5a5a5a5a5a5a5b5a5a5a5a5a5a5a5a, 1'b1, 0};
        vecs[5] = '{2, {128{1'b1}}, 128'h0, ~XORC, 1'b0, 0};

        repeat (3) @(posedge iClk);
        #1;
        iRst = 1'b0;
        @(negedge iClk);
        chk("rst_outputs", 256'({oReqReady, oRspValid, oRspId, oRspErr, oCoreStart, oBusy}), 256'(0));
        chk("rst_rsp_data", 256'(oRspData), 256'(0));
        chk("rst_core_ops", {oCorePlaintext, oCoreKey}, 256'(0));

        run_fair();
        for (int i = 0; i < 6; i++) run_job(vecs[i]);
        run_reset_mid();
`ifdef AES_ARB_TIMEOUT_EN
        run_timeout();
`endif
        repeat (3) @(negedge iClk);
        chk("sb_empty", 256'(exp_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
